// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial sequence detector. It matches a 1..MAX_LEN bit pattern, with
// overlap selectable per bit, a registered match pulse and a saturating match counter.
module seq_detect_prog #(
    parameter int unsigned                MAX_LEN     = 8,
    parameter int unsigned                LEN_W       = $clog2(MAX_LEN + 1),
    parameter int unsigned                CNT_W       = 8,
    parameter logic        [MAX_LEN-1:0]  DEF_PATTERN = 8'b0000_0110,
    parameter int unsigned                DEF_LEN     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               bit_in,
    input  logic               bit_valid,
    input  logic               overlap_en,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cnt_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic [LEN_W-1:0]   cur_len
);

    localparam logic [LEN_W-1:0] MaxLenW = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] DefLenW = LEN_W'(DEF_LEN);

    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [MAX_LEN-1:0] window_q, window_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               match_q, match_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [LEN_W-1:0]   len_load;
    logic [MAX_LEN-1:0] window_shift;
    logic [LEN_W-1:0]   fill_inc;
    logic [MAX_LEN-1:0] len_mask;
    logic               hit;

    always_comb begin
        len_load = cfg_len;
        if (cfg_len == '0 || cfg_len > MaxLenW) begin
            len_load = MaxLenW;
        end

        window_shift = {window_q[MAX_LEN-2:0], bit_in};
        fill_inc     = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);

        // Pattern bits at or above the active length never take part in the compare.
        len_mask = '0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            len_mask[i] = (i < int'(len_q));
        end

        hit = bit_valid && !cfg_load && (fill_inc == len_q)
              && (((window_shift ^ pattern_q) & len_mask) == '0);
    end

    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        window_d  = window_q;
        fill_d    = fill_q;
        match_d   = 1'b0;

        if (cfg_load) begin
            // A bit sampled together with a load is dropped on purpose.
            pattern_d = cfg_pattern;
            len_d     = len_load;
            window_d  = '0;
            fill_d    = '0;
        end else if (bit_valid) begin
            window_d = window_shift;
            match_d  = hit;
            fill_d   = (hit && !overlap_en) ? '0 : fill_inc;
        end

        count_d = count_q;
        if (cnt_clr) begin
            count_d = '0;
        end else if (hit && count_q != '1) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern_q <= DEF_PATTERN;
            len_q     <= DefLenW;
            window_q  <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            window_q  <= window_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            count_q   <= count_d;
        end
    end

    assign match       = match_q;
    assign match_count = count_q;
    assign cur_len     = len_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Randomised and directed bench for seq_detect_prog; a history-queue model predicts every output.
module tb_seq_detect_prog;

    logic       clk = 1'b0;
    logic       reset;
    logic       bit_in, bit_valid, overlap_en, cfg_load, cnt_clr;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       match, match2;
    logic [7:0] match_count;
    logic [1:0] match_count2;
    logic [3:0] cur_len, cur_len2;

    int checks = 0;
    int errors = 0;

    // Reference model: bits since the last restart, newest at the back.
    bit         hist[$];
    logic [7:0] m_pat;
    int         m_len;
    bit         m_match;
    int         m_cnt8, m_cnt2;

    always #5 clk = ~clk;

    seq_detect_prog dut (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .overlap_en(overlap_en), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cnt_clr(cnt_clr), .match(match), .match_count(match_count),
        .cur_len(cur_len)
    );

    seq_detect_prog #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .overlap_en(overlap_en), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cnt_clr(cnt_clr), .match(match2), .match_count(match_count2),
        .cur_len(cur_len2)
    );

    task automatic model_reset();
        hist.delete();
        m_pat = 8'b0000_0110;
        m_len = 4;
        m_match = 0;
        m_cnt8 = 0;
        m_cnt2 = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bit_in = 0; bit_valid = 0; overlap_en = 0; cfg_load = 0; cnt_clr = 0;
        cfg_pattern = '0; cfg_len = '0;
        #2;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Drives one cycle and advances the model; callers compare afterwards.
    task automatic step(input bit v, input bit b, input bit ov, input bit ld,
                        input logic [7:0] pat, input logic [3:0] len, input bit clr);
        bit hit;
        @(negedge clk);
        bit_valid = v; bit_in = b; overlap_en = ov; cfg_load = ld;
        cfg_pattern = pat; cfg_len = len; cnt_clr = clr;
        @(posedge clk);
        hit = 0;
        if (ld) begin
            m_pat = pat;
            m_len = (len == 0 || len > 8) ? 8 : int'(len);
            hist.delete();
        end else if (v) begin
            hist.push_back(b);
            if (hist.size() > 8) void'(hist.pop_front());
            if (hist.size() >= m_len) begin
                hit = 1;
                for (int k = 0; k < m_len; k++)
                    if (hist[hist.size() - 1 - k] != m_pat[k]) hit = 0;
            end
            if (hit && !ov) hist.delete();
        end
        m_match = hit;
        if (clr) begin
            m_cnt8 = 0;
            m_cnt2 = 0;
        end else if (hit) begin
            m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
            m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
        end
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (match !== 1'b0 || match_count !== 8'd0 || cur_len !== 4'd4 || match2 !== 1'b0) begin
            errors++;
            $display("FAIL reset: match=%b cnt=%0d len=%0d expected 0 0 4", match,
                     match_count, cur_len);
        end
    endtask

    task automatic test_stream(input bit ov, input int exp_cnt);
        bit bits[7] = '{0, 1, 1, 0, 1, 1, 0};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(1, bits[i], ov, 0, 8'h00, 4'd0, 0);
            checks++;
            if (match !== m_match || match_count !== 8'(m_cnt8)) begin
                errors++;
                $display("FAIL stream ov=%0d bit %0d: match=%b cnt=%0d expected %b %0d", ov, i,
                         match, match_count, m_match, m_cnt8);
            end
        end
        checks++;
        if (match_count !== 8'(exp_cnt)) begin
            errors++;
            $display("FAIL stream ov=%0d total: cnt=%0d expected %0d", ov, match_count, exp_cnt);
        end
    endtask

    task automatic test_gapped_len8();
        bit bits[8] = '{1, 0, 1, 1, 0, 0, 1, 1};
        do_reset();
        step(0, 0, 0, 1, 8'b1011_0011, 4'd8, 0);
        for (int i = 0; i < 16; i++) begin
            step(i % 2 == 0, bits[i / 2], 0, 0, 8'h00, 4'd0, 0);
            checks++;
            if (match !== m_match || match_count !== 8'(m_cnt8) || cur_len !== 4'd8) begin
                errors++;
                $display("FAIL gapped cycle %0d: match=%b cnt=%0d len=%0d expected %b %0d 8", i,
                         match, match_count, cur_len, m_match, m_cnt8);
            end
        end
        checks++;
        if (match_count !== 8'd1) begin
            errors++;
            $display("FAIL gapped total: cnt=%0d expected 1", match_count);
        end
    endtask

    task automatic test_len1();
        bit bits[4] = '{1, 1, 0, 1};
        do_reset();
        for (int ov = 0; ov < 2; ov++) begin
            step(0, 0, 0, 1, 8'b0000_0001, 4'd1, 1);
            for (int i = 0; i < 4; i++) begin
                step(1, bits[i], ov[0], 0, 8'h00, 4'd0, 0);
                checks++;
                if (match !== m_match || match_count !== 8'(m_cnt8)) begin
                    errors++;
                    $display("FAIL len1 ov=%0d bit %0d: match=%b cnt=%0d expected %b %0d", ov, i,
                             match, match_count, m_match, m_cnt8);
                end
            end
            checks++;
            if (match_count !== 8'd3) begin
                errors++;
                $display("FAIL len1 ov=%0d total: cnt=%0d expected 3", ov, match_count);
            end
        end
        step(0, 0, 0, 1, 8'b0000_0001, 4'd0, 0);
        checks++;
        if (cur_len !== 4'd8) begin
            errors++;
            $display("FAIL len0 clamp: cur_len=%0d expected 8", cur_len);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        step(0, 0, 1, 1, 8'b0000_0011, 4'd2, 0);
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 1, 0, 8'h00, 4'd0, 0);
            checks++;
            if (match2 !== m_match || match_count2 !== 2'(m_cnt2)) begin
                errors++;
                $display("FAIL saturate bit %0d: match=%b cnt=%0d expected %b %0d", i, match2,
                         match_count2, m_match, m_cnt2);
            end
        end
        checks++;
        if (match_count2 !== 2'd3 || match_count !== 8'd5) begin
            errors++;
            $display("FAIL saturate total: cnt2=%0d cnt8=%0d expected 3 5", match_count2,
                     match_count);
        end
        step(1, 1, 1, 0, 8'h00, 4'd0, 1);
        checks++;
        if (match2 !== 1'b1 || match_count2 !== 2'd0 || match_count !== 8'd0) begin
            errors++;
            $display("FAIL clear with hit: match=%b cnt2=%0d cnt8=%0d expected 1 0 0", match2,
                     match_count2, match_count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1, 0, 0, 0, 8'h00, 4'd0, 0);
        step(1, 1, 0, 0, 8'h00, 4'd0, 0);
        step(1, 1, 0, 0, 8'h00, 4'd0, 0);
        do_reset();
        step(1, 0, 0, 0, 8'h00, 4'd0, 0);
        checks++;
        if (match !== 1'b0 || match_count !== 8'd0) begin
            errors++;
            $display("FAIL reset mid: match=%b cnt=%0d expected 0 0", match, match_count);
        end
        // The first pattern bit arrives with the load and must be dropped.
        step(1, 0, 0, 1, 8'b0000_0110, 4'd4, 0);
        step(1, 1, 0, 0, 8'h00, 4'd0, 0);
        step(1, 1, 0, 0, 8'h00, 4'd0, 0);
        step(1, 0, 0, 0, 8'h00, 4'd0, 0);
        checks++;
        if (match !== 1'b0 || match_count !== 8'd0) begin
            errors++;
            $display("FAIL load drops bit: match=%b cnt=%0d expected 0 0", match, match_count);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit ld = ($urandom_range(0, 39) == 0);
            bit v = ($urandom_range(0, 3) != 0);
            step(v, 1'($urandom), 1'($urandom), ld, 8'($urandom), 4'($urandom_range(0, 15)),
                 $urandom_range(0, 99) == 0);
            checks++;
            if (match !== m_match || match_count !== 8'(m_cnt8) || cur_len !== 4'(m_len)
                || match2 !== m_match || match_count2 !== 2'(m_cnt2)) begin
                errors++;
                $display("FAIL random cycle %0d: match=%b cnt=%0d len=%0d cnt2=%0d expected %b %0d %0d %0d",
                         i, match, match_count, cur_len, match_count2, m_match, m_cnt8, m_len,
                         m_cnt2);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        bit_in = 0; bit_valid = 0; overlap_en = 0; cfg_load = 0; cnt_clr = 0;
        cfg_pattern = '0; cfg_len = '0;
        test_reset();
        test_stream(0, 1);
        test_stream(1, 2);
        test_gapped_len8();
        test_len1();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detect_prog.md
Name: seq_detect_prog

Overview:
Parametrised, runtime-programmable serial sequence detector. It is the successor to the fixed 4-bit Moore detectors. It compares a 1-bit serial stream against a loadable pattern of 1..MAX_LEN bits, with overlapping or non-overlapping detection selectable per bit. It gives a registered (Moore) match pulse and a saturating match counter, and sits behind serial protocol front-ends as a sync/preamble spotter.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
LEN_W, $clog2(MAX_LEN+1), width of length fields
CNT_W, 8, width of the match counter
DEF_PATTERN, 8'b0000_0110, pattern after reset (LSB = last bit received)
DEF_LEN, 4, pattern length after reset

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
bit_in  input  1  serial data bit
bit_valid  input  1  bit_in sampled this edge when high
overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping
cfg_load  input  1  latch cfg_pattern/cfg_len, restart detection
cfg_pattern  input  MAX_LEN  new pattern; bit[len-1] = first bit, bit[0] = last bit
cfg_len  input  LEN_W  new pattern length
cnt_clr  input  1  synchronous clear of match_count
match  output  1  registered one-cycle detection pulse
match_count  output  CNT_W  saturating count of detections
cur_len  output  LEN_W  active pattern length

Behaviour:
- Reset (async, active-high): pattern=DEF_PATTERN, len=DEF_LEN, window=0, fill=0, match=0, match_count=0, cur_len=DEF_LEN.
- Window: MAX_LEN shift register. On a bit_valid edge: window <= {window[MAX_LEN-2:0], bit_in}.
- Fill: counter of valid bits since restart, saturating at len.
- Hit condition, evaluated on the sampling edge using the post-shift window: fill_next == len and the low len bits of the window equal the low len bits of the pattern. Pattern bits above len are ignored.
- Moore output:
  - match is registered high for exactly the one cycle after the edge that sampled the completing bit; otherwise 0.
  - No bit_valid means match=0 the next cycle.
- Overlap mode (overlap_en=1 at the completing edge): fill is unchanged after a hit, so the suffix bits can start the next match.
- Non-overlap mode (overlap_en=0): fill <= 0 on a hit, so len fresh bits are needed before the next hit.
- overlap_en is sampled per edge and may change mid-stream; it affects only the edge it is sampled on.
- cfg_load:
  - Latches the pattern, latches len, clears window and fill, and forces match=0 next cycle.
  - A bit_valid on the same edge is discarded (cfg_load wins).
  - cfg_len of 0 or above MAX_LEN is clamped to MAX_LEN.
  - cur_len updates on the same edge.
- match_count:
  - Increments on the same edge that sets match.
  - Saturates at 2^CNT_W-1.
  - cnt_clr zeroes it; cnt_clr together with a hit gives 0 (clear wins).
  - cfg_load does not clear the counter.
- len=1: every bit equal to pattern[0] is a hit in both modes.
- Reset mid-sequence: all partial progress is lost and no match is emitted.

Test Plan:
- Defaults (0110, len 4), overlap_en=0, bits 0,1,1,0,1,1,0 back-to-back -> single match pulse the cycle after bit 4; match_count=1.
- Same stream, overlap_en=1 -> match after bit 4 and after bit 7; match_count=2.
- Load cfg_pattern=8'b1011_0011, cfg_len=8; stream 1,0,1,1,0,0,1,1 with bit_valid gapped (alternate cycles) -> one match after the 8th valid bit only; match stays 0 on idle cycles.
- Load pattern 1, cfg_len=1; stream 1,1,0,1 -> three matches in both modes. Then load cfg_len=0 -> cur_len=8.
- CNT_W overridden to 2, overlap mode, pattern 11 len 2, stream of 6 ones -> count saturates at 3. Then cnt_clr asserted on the same edge as a hit -> match=1, match_count=0.
- Assert reset after bits 0,1,1 of 0110, then send 0 -> no match; match=0, count=0. Also drive cfg_load together with bit_valid -> bit ignored, fill=0.
